// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM-stage controller for a pipelined CPU. It turns a load or
//                store request from the EX stage into a multi-cycle SRAM
//                access and freezes the upstream pipeline until it completes.
//                Optional macro MEM_READ_BUFFER_EN adds a one-entry read
//                buffer that returns repeated loads without an SRAM access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            store_data_in,
  input  logic [31:0]            sram_rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic [31:0]            mem_read_data,
  output logic                   ready
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   w_req;
  logic                   w_last;
  logic                   w_hit;
  logic [31:0]            w_buf_data;
  logic [31:0]            w_byte_off;
  logic [SRAM_ADDR_W-1:0] w_req_word;

  assign w_req      = mem_read_in | mem_write_in;
  // Word index relative to the data window; wraps naturally for out-of-range
  // addresses, and the byte-lane bits are simply shifted away.
  assign w_byte_off = alu_result_in - DATA_BASE;
  assign w_req_word = SRAM_ADDR_W'(w_byte_off >> 2);
  assign w_last     = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef MEM_READ_BUFFER_EN
  logic                   buf_valid_q;
  logic [SRAM_ADDR_W-1:0] buf_addr_q;
  logic [31:0]            buf_data_q;

  // Read buffer: filled by each completed read, kept coherent by completed writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 32'd0;
    end else if (w_last) begin
      if (!wr_q) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= addr_q;
        buf_data_q  <= sram_rdata;
      end else if (buf_valid_q && (buf_addr_q == addr_q)) begin
        buf_data_q  <= wdata_q;
      end
    end
  end

  // A write takes priority, so a simultaneous read+write never hits.
  assign w_hit      = (state_q == IDLE) && mem_read_in && !mem_write_in &&
                      buf_valid_q && (buf_addr_q == w_req_word);
  assign w_buf_data = buf_data_q;
`else
  assign w_hit      = 1'b0;
  assign w_buf_data = rdata_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic, request latching and pipeline stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (w_hit) begin
          // Keep the hit value visible after the request goes away.
          rdata_d = w_buf_data;
        end else if (w_req) begin
          ready   = 1'b0;
          addr_d  = w_req_word;
          wdata_d = store_data_in;
          wr_d    = mem_write_in;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // Single release cycle; held inputs are not re-sampled here.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_we_n     = !((state_q == ACCESS) && wr_q);
  assign sram_oe_n     = !((state_q == ACCESS) && !wr_q);
  assign mem_read_data = w_hit ? w_buf_data : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Self-checking bench for mem_stage_ctrl with an SRAM model
//                and a scoreboard of expected transaction results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int          WC   = 4;
  localparam int          AW   = 16;
  localparam logic [31:0] BASE = 32'd1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read_in;
  logic          mem_write_in;
  logic [31:0]   alu_result_in;
  logic [31:0]   store_data_in;
  logic [31:0]   sram_rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [31:0]   mem_read_data;
  logic          ready;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .WAIT_CYCLES (WC),
    .SRAM_ADDR_W (AW),
    .DATA_BASE   (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .sram_rdata    (sram_rdata),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_we_n     (sram_we_n),
    .sram_oe_n     (sram_oe_n),
    .mem_read_data (mem_read_data),
    .ready         (ready)
  );

  // SRAM model driven by the DUT pins
  logic [31:0] sram_mem [0:65535];
  logic [31:0] exp_mem  [0:65535];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] = sram_wdata;
  end

  assign sram_rdata = sram_oe_n ? 32'hBAD0BAD0 : sram_mem[sram_addr];

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
    bit          wr;
    bit          rd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_rdata;
  bit          bvalid;
  logic [AW-1:0] baddr;
  logic [31:0] bdata;

  function automatic logic [31:0] init_val(input int unsigned i);
    logic [31:0] v;
    v = i;
    return {v[15:0] ^ 16'h5A5A, ~v[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Issue one request, predict its outcome, then observe it to completion.
  task automatic do_op(input string tag, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    logic [31:0]   diff;
    logic [AW-1:0] word;
    bit            is_rd;
    bit            hit;
    exp_t          e;
    int            cyc, we_cnt, oe_cnt, bad;
    bit            timeout;

    diff  = a - BASE;
    word  = diff[17:2];
    is_rd = rd && !wr;
    hit   = 1'b0;
`ifdef MEM_READ_BUFFER_EN
    hit   = is_rd && bvalid && (baddr == word);
`endif
    e.tag = tag;
    e.wr  = wr;
    e.rd  = is_rd;
    e.lat = hit ? 0 : WC + 1;
    if (is_rd) e.data = hit ? bdata : exp_mem[word];
    else       e.data = exp_rdata;
    sb.push_back(e);

    if (wr) begin
      exp_mem[word] = d;
      if (bvalid && baddr == word) bdata = d;
    end else if (is_rd) begin
      exp_rdata = e.data;
      bvalid    = 1'b1;
      baddr     = word;
      bdata     = e.data;
    end

    @(posedge clk);
    #1;
    mem_read_in   = rd;
    mem_write_in  = wr;
    alu_result_in = a;
    store_data_in = d;
    cyc = 0; we_cnt = 0; oe_cnt = 0; bad = 0; timeout = 1'b0;
    forever begin
      #1;
      if (!sram_we_n) begin
        we_cnt++;
        if (sram_addr !== word || sram_wdata !== d) bad++;
      end
      if (!sram_oe_n) begin
        oe_cnt++;
        if (sram_addr !== word) bad++;
      end
      if (ready === 1'b1) break;
      if (cyc >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end

    e = sb.pop_front();
    check({e.tag, ".timeout"}, 32'(timeout), 32'd0);
    check({e.tag, ".lat"},     32'(cyc), 32'(e.lat));
    check({e.tag, ".rdata"},   mem_read_data, e.data);
    check({e.tag, ".we_cyc"},  32'(we_cnt), e.wr ? 32'(WC) : 32'd0);
    check({e.tag, ".oe_cyc"},  32'(oe_cnt), (e.rd && e.lat != 0) ? 32'(WC) : 32'd0);
    check({e.tag, ".bus"},     32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = init_val(i);
      exp_mem[i]  = init_val(i);
    end
    exp_rdata     = 32'd0;
    bvalid        = 1'b0;
    baddr         = '0;
    bdata         = 32'd0;
    rst           = 1'b0;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    alu_result_in = 32'd0;
    store_data_in = 32'd0;

    #3;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.we_n",  32'(sram_we_n), 32'd1);
    check("rst.oe_n",  32'(sram_oe_n), 32'd1);
    check("rst.addr",  32'(sram_addr), 32'd0);
    check("rst.wdata", sram_wdata, 32'd0);
    check("rst.rdata", mem_read_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_op("st1032",   1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    do_op("ld1032",   1'b1, 1'b0, 32'd1032, 32'h0);
    do_op("ld1036a",  1'b1, 1'b0, 32'd1036, 32'h0);
    do_op("ld1036b",  1'b1, 1'b0, 32'd1036, 32'h0);
    do_op("st1036",   1'b0, 1'b1, 32'd1036, 32'h00000001);
    do_op("ld1036c",  1'b1, 1'b0, 32'd1036, 32'h0);
    do_op("rdwr1024", 1'b1, 1'b1, 32'd1024, 32'h12345678);
    do_op("ld1024",   1'b1, 1'b0, 32'd1024, 32'h0);
    do_op("st_wrap",  1'b0, 1'b1, 32'd0,    32'hCAFEF00D);
    do_op("ld_wrap",  1'b1, 1'b0, 32'd3,    32'h0);
    do_op("ld_alias", 1'b1, 1'b0, 32'd1024 + 32'h40000 + 32'd8, 32'h0);
    idle(2);

    // Abort a store in its second ACCESS cycle
    @(posedge clk);
    #1;
    mem_write_in  = 1'b1;
    alu_result_in = 32'd1100;
    store_data_in = 32'h55AA55AA;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    mem_write_in = 1'b0;
    #1;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.we_n",  32'(sram_we_n), 32'd1);
    check("abort.oe_n",  32'(sram_oe_n), 32'd1);
    check("abort.addr",  32'(sram_addr), 32'd0);
    check("abort.wdata", sram_wdata, 32'd0);
    check("abort.rdata", mem_read_data, 32'd0);
    exp_rdata = 32'd0;
    bvalid    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_op("ld_post_rst", 1'b1, 1'b0, 32'd1032, 32'h0);

    for (int k = 0; k < 8; k++) begin
      bit          w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = BASE + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      do_op(w ? "rnd_st" : "rnd_ld", !w, w, a, $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, SRAM access cycles per operation (legal 1..15).
REQ-002 Parameter SRAM_ADDR_W, default 16, SRAM word-address width.
REQ-003 Parameter DATA_BASE, default 32'd1024, byte address mapped to SRAM word 0.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 mem_read_in  in  1  load request from EX stage register.
REQ-007 mem_write_in  in  1  store request from EX stage register.
REQ-008 alu_result_in  in  32  byte address computed by EX.
REQ-009 store_data_in  in  32  forwarded store value from EX.
REQ-010 sram_rdata  in  32  SRAM read data.
REQ-011 sram_addr  out  SRAM_ADDR_W  SRAM word address.
REQ-012 sram_wdata  out  32  SRAM write data.
REQ-013 sram_we_n  out  1  active-low write enable.
REQ-014 sram_oe_n  out  1  active-low output enable.
REQ-015 mem_read_data  out  32  load result to MEM/WB register.
REQ-016 ready  out  1  high = pipeline may advance; low = freeze all upstream stages.

Function
REQ-017 States SHALL be IDLE, ACCESS, DONE.
REQ-018 Request = mem_read_in | mem_write_in; simultaneous read and write SHALL be executed as a write only.
REQ-019 IDLE with request SHALL latch word address, store data and op type, load counter with WAIT_CYCLES-1, go ACCESS.
REQ-020 Word address SHALL be bits [SRAM_ADDR_W+1:2] of (alu_result_in - DATA_BASE), 32-bit modulo subtraction; bits [1:0] ignored; out-of-range addresses wrap modulo 2^SRAM_ADDR_W.
REQ-021 ACCESS SHALL decrement the counter each cycle; at counter 0 go DONE; a read SHALL capture sram_rdata into mem_read_data on that edge.
REQ-022 DONE SHALL go to IDLE unconditionally after one cycle (no re-trigger on held inputs).
REQ-023 ready SHALL be combinational: 1 in IDLE without request, 0 in IDLE with request, 0 in ACCESS, 1 in DONE.
REQ-024 Latency: request first seen in cycle 0 -> ready high in cycle WAIT_CYCLES+1; a back-to-back request in the following IDLE cycle SHALL start a new access.
REQ-025 In ACCESS, sram_addr/sram_wdata SHALL come from the latched values; sram_we_n=0 for writes, sram_oe_n=0 for reads, both 1 otherwise.
REQ-026 mem_read_data SHALL hold its last value until the next completed read; writes SHALL not change it.
REQ-027 Upstream SHALL hold inputs stable while ready=0; the block SHALL use only latched values during ACCESS.

Reset
REQ-028 rst low SHALL immediately force IDLE, counter 0, mem_read_data 0, sram_addr 0, sram_wdata 0, sram_we_n 1, sram_oe_n 1, including mid-ACCESS (aborted write may leave SRAM word undefined).
REQ-029 After rst rises, the first edge SHALL behave as IDLE.

Configuration
REQ-030 Macro MEM_READ_BUFFER_EN defined: a one-entry buffer (valid, word address, data) SHALL be filled by each completed read.
REQ-031 With MEM_READ_BUFFER_EN, a read in IDLE matching a valid entry (and no write) SHALL hit: ready=1 same cycle, mem_read_data driven from buffer combinationally, no SRAM access, state stays IDLE.
REQ-032 With MEM_READ_BUFFER_EN, a completed write to the buffered address SHALL update buffer data; reset SHALL clear valid.
REQ-033 Without MEM_READ_BUFFER_EN, no buffer logic SHALL exist and every read SHALL take full latency.

Verification
REQ-034 Store 0xDEADBEEF to 1032, WAIT_CYCLES=4 -> ready low cycles 0-4, sram_we_n low 4 cycles at sram_addr 2, ready high cycle 5.
REQ-035 Load 1032 with sram_rdata 0xDEADBEEF -> sram_oe_n low 4 cycles, mem_read_data=0xDEADBEEF and ready=1 in cycle 5.
REQ-036 Read and write both high to 1024 -> write only, sram_oe_n stays 1, mem_read_data unchanged.
REQ-037 rst low in 2nd ACCESS cycle -> all outputs at reset values immediately; new load after release completes normally.
REQ-038 MEM_READ_BUFFER_EN: load 1036 twice back-to-back -> second ready=1 in same cycle with no SRAM enable; store 0x1 to 1036 then load 1036 -> hit returns 0x1.
